cr_kme_fifo_unpacker: RTL and testbench

Downstream consumer of the KME 71-bit RAM FIFO. Pops entries using the FIFO's valid/ack read handshake and splits each 64-bit payload into one or two 32-bit beats for the key-engine datapath. Flags ECC uncorrectable errors and drops any packet that contains one.

---
 rtl/cr_kme_fifo_unpacker.sv | 160 ++++++++++++++++
 tb/tb_cr_kme_fifo_unpacker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_fifo_unpacker.sv
// rtl/cr_kme_fifo_unpacker.sv - pops 71-bit KME FIFO entries and emits 32-bit beats, dropping ECC-corrupt packets
module cr_kme_fifo_unpacker #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [70:0]          fifo_out,
    input  logic                 fifo_out_valid,
    input  logic                 fifo_mbe,
    output logic                 fifo_out_ack,
    output logic [31:0]          out_data,
    output logic                 out_sot,
    output logic                 out_eoi,
    output logic [3:0]           out_tag,
    output logic                 out_valid,
    input  logic                 out_ack,
    input  logic                 err_clr,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {EMPTY, LO, HI, DISCARD} state_t;

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    state_t      state;
    state_t      state_nxt;
    state_t      pop_target;
    logic [63:0] hold_payload;
    logic        hold_sot;
    logic        hold_eoi;
    logic        hold_half;
    logic [3:0]  hold_tag;

    logic        in_sot;
    logic        in_eoi;
    logic        in_half;
    logic [3:0]  in_tag;
    logic [63:0] in_payload;

    logic        beat_accept;
    logic        last_beat_accept;
    logic        pop;
    logic        mbe_pop;
    logic        load;

    assign in_sot     = fifo_out[70];
    assign in_eoi     = fifo_out[69];
    assign in_half    = fifo_out[68];
    assign in_tag     = fifo_out[67:64];
    assign in_payload = fifo_out[63:0];

    always_comb begin
        beat_accept      = out_valid & out_ack;
        last_beat_accept = beat_accept & (((state == LO) & hold_half) | (state == HI));
        // Gated by rst_n so nothing is popped while the block is held in reset.
        fifo_out_ack     = rst_n & fifo_out_valid &
                           ((state == EMPTY) | (state == DISCARD) | last_beat_accept);
        pop              = fifo_out_valid & fifo_out_ack;
        mbe_pop          = pop & fifo_mbe;
        load             = pop & ~fifo_mbe & (state != DISCARD);
    end

    always_comb begin
        pop_target = LO;
        if (fifo_mbe) begin
            pop_target = in_eoi ? EMPTY : DISCARD;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (pop) begin
                    state_nxt = pop_target;
                end
            end
            LO: begin
                if (beat_accept) begin
                    if (!hold_half) begin
                        state_nxt = HI;
                    end else if (pop) begin
                        state_nxt = pop_target;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            HI: begin
                if (beat_accept) begin
                    state_nxt = pop ? pop_target : EMPTY;
                end
            end
            DISCARD: begin
                // Any eoi ends the corrupt packet, clean or not.
                if (pop && in_eoi) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            hold_payload <= '0;
            hold_sot     <= 1'b0;
            hold_eoi     <= 1'b0;
            hold_half    <= 1'b0;
            hold_tag     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                hold_payload <= in_payload;
                hold_sot     <= in_sot;
                hold_eoi     <= in_eoi;
                hold_half    <= in_half;
                hold_tag     <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (mbe_pop) begin
            err_sticky <= 1'b1;
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

    // Beats are decoded straight from the holding register, so they stay stable under backpressure.
    always_comb begin
        out_valid = (state == LO) | (state == HI);
        out_data  = '0;
        out_sot   = 1'b0;
        out_eoi   = 1'b0;
        out_tag   = '0;
        if (state == LO) begin
            out_data = hold_payload[31:0];
            out_sot  = hold_sot;
            out_eoi  = hold_eoi & hold_half;
            out_tag  = hold_tag;
        end else if (state == HI) begin
            out_data = hold_payload[63:32];
            out_eoi  = hold_eoi;
            out_tag  = hold_tag;
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_unpacker.sv
// tb/tb_cr_kme_fifo_unpacker.sv - randomized bench for cr_kme_fifo_unpacker against a packet-level beat model
module tb_cr_kme_fifo_unpacker;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [70:0]  fifo_out;
    logic         fifo_out_valid;
    logic         fifo_mbe;
    logic         fifo_out_ack;
    logic [31:0]  out_data;
    logic         out_sot;
    logic         out_eoi;
    logic [3:0]   out_tag;
    logic         out_valid;
    logic         out_ack;
    logic         err_clr;
    logic         err_sticky;
    logic [W-1:0] err_cnt;

    cr_kme_fifo_unpacker #(.ERR_CNT_W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_out(fifo_out),
        .fifo_out_valid(fifo_out_valid),
        .fifo_mbe(fifo_mbe),
        .fifo_out_ack(fifo_out_ack),
        .out_data(out_data),
        .out_sot(out_sot),
        .out_eoi(out_eoi),
        .out_tag(out_tag),
        .out_valid(out_valid),
        .out_ack(out_ack),
        .err_clr(err_clr),
        .err_sticky(err_sticky),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [70:0] e;
        logic        mbe;
    } ent_t;

    typedef struct {
        logic [31:0] d;
        logic        sot;
        logic        eoi;
        logic [3:0]  tag;
        logic        is_hi;
    } beat_t;

    ent_t  src[$];
    beat_t expq[$];
    bit    dropping;
    int    m_cnt;
    bit    m_sticky;
    int    checks;
    int    failures;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_ent(input bit sot, input bit eoi, input bit half,
                            input logic [3:0] tag, input logic [63:0] d, input bit mbe);
        ent_t x;
        x.e   = {sot, eoi, half, tag, d};
        x.mbe = mbe;
        src.push_back(x);
    endtask

    task automatic gen_packet();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            push_ent(i == 0, i == n - 1, $urandom_range(0, 1) == 1, 4'($urandom),
                     {$urandom, $urandom}, $urandom_range(0, 7) == 0);
        end
    endtask

    // Expected beats follow from the popped entries alone: corrupt packets vanish up to their eoi.
    task automatic model_pop(input ent_t x);
        beat_t b;
        logic  sot, eoi, half;
        logic [3:0] tag;
        logic [63:0] d;
        {sot, eoi, half, tag, d} = x.e;
        if (x.mbe) begin
            dropping = !eoi;
        end else if (dropping) begin
            dropping = !eoi;
        end else begin
            b.d = d[31:0]; b.sot = sot; b.eoi = eoi & half; b.tag = tag; b.is_hi = 1'b0;
            expq.push_back(b);
            if (!half) begin
                b.d = d[63:32]; b.sot = 1'b0; b.eoi = eoi; b.tag = tag; b.is_hi = 1'b1;
                expq.push_back(b);
            end
        end
    endtask

    task automatic step(input bit v, input bit a, input bit c);
        bit   exp_ack;
        ent_t x;
        @(negedge clk);
        fifo_out_valid = v && (src.size() > 0);
        if (src.size() > 0) begin
            fifo_out = src[0].e;
            fifo_mbe = src[0].mbe;
        end else begin
            fifo_out = {7'($urandom), $urandom, $urandom};
            fifo_mbe = 1'($urandom);
        end
        out_ack = a;
        err_clr = c;
        #1;
        exp_ack = fifo_out_valid && (expq.size() == 0 || (expq.size() == 1 && a));
        chk("out_valid", out_valid, expq.size() > 0);
        if (expq.size() > 0) begin
            chk("out_data", out_data, expq[0].d);
            chk("out_sot", out_sot, expq[0].sot);
            chk("out_eoi", out_eoi, expq[0].eoi);
            chk("out_tag", out_tag, expq[0].tag);
        end
        chk("fifo_out_ack", fifo_out_ack, exp_ack);
        chk("err_sticky", err_sticky, m_sticky);
        chk("err_cnt", err_cnt, m_cnt);
        if (expq.size() > 0 && a) begin
            void'(expq.pop_front());
        end
        if (exp_ack) begin
            x = src.pop_front();
            model_pop(x);
        end
        if (c) begin
            m_cnt = 0;
            m_sticky = 0;
        end else if (exp_ack && x.mbe) begin
            m_sticky = 1;
            if (m_cnt < (1 << W) - 1) m_cnt++;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        fifo_out_valid = 1'b0;
        out_ack = 1'b0;
        err_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_fifo_out_ack", fifo_out_ack, 1'b0);
        chk("rst_err_cnt", err_cnt, 0);
        expq.delete();
        dropping = 0;
        m_cnt = 0;
        m_sticky = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        dropping = 0;
        m_cnt = 0;
        m_sticky = 0;
        rst_n = 1'b0;
        fifo_out = '0;
        fifo_out_valid = 1'b1;
        fifo_mbe = 1'b0;
        out_ack = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_sot", out_sot, 1'b0);
        chk("reset_out_eoi", out_eoi, 1'b0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_err_sticky", err_sticky, 1'b0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_fifo_out_ack", fifo_out_ack, 1'b0);
        @(negedge clk);
        fifo_out_valid = 1'b0;
        rst_n = 1'b1;

        // single full entry
        push_ent(1, 1, 0, 4'd5, 64'h1111_2222_3333_4444, 0);
        repeat (4) step(1, 1, 0);

        // half entry followed back-to-back by a full entry
        push_ent(1, 0, 1, 4'd2, 64'h0000_0000_A5A5_0001, 0);
        push_ent(0, 1, 0, 4'd2, 64'hBEEF_0002_CAFE_0003, 0);
        repeat (5) step(1, 1, 0);

        // backpressure on the LO beat
        push_ent(1, 1, 0, 4'd7, 64'h7777_0000_8888_0000, 0);
        push_ent(1, 1, 1, 4'd9, 64'h0000_0000_9999_0001, 0);
        step(1, 1, 0);
        repeat (4) step(1, 0, 0);
        repeat (4) step(1, 1, 0);

        // corrupt first entry drops the whole packet, next packet passes
        push_ent(1, 0, 0, 4'd3, 64'h1, 1);
        push_ent(0, 0, 0, 4'd3, 64'h2, 0);
        push_ent(0, 1, 1, 4'd3, 64'h3, 0);
        push_ent(1, 1, 0, 4'd4, 64'h4444_0000_5555_0000, 0);
        repeat (8) step(1, 1, 0);

        // counter saturation, then clear coinciding with an mbe pop
        repeat (5) push_ent(1, 1, 0, 4'd1, 64'hDEAD, 1);
        repeat (6) step(1, 1, 0);
        push_ent(1, 1, 0, 4'd1, 64'hDEAD, 1);
        step(1, 1, 1);
        repeat (2) step(1, 1, 0);

        // reset during a HI beat
        push_ent(1, 1, 0, 4'd6, 64'h6666_0001_6666_0002, 0);
        push_ent(0, 1, 0, 4'd8, 64'h8888_0001_8888_0002, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        mid_reset();
        repeat (4) step(1, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 4) gen_packet();
            if (expq.size() == 1 && expq[0].is_hi && $urandom_range(0, 49) == 0) begin
                mid_reset();
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        repeat (6) step(0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
